// File: rtl/fetch_unit.sv
// PC register and instruction-fetch stage feeding the Control decoder.
// Next PC comes from sequential increment, a branch-target LUT, or a halt hold.
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [8:0]       instr_in,
    input  logic             branch_taken,
    input  logic             halt_in,
    input  logic             lut_we,
    input  logic [4:0]       lut_addr,
    input  logic [PC_W-1:0]  lut_data,
    output logic [PC_W-1:0]  pc,
    output logic [5:0]       opcode,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] branch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [PC_W-1:0]  lut [32];
    logic [4:0]       br_idx;

    assign br_idx = instr_in[4:0];

    // Next-state and next-PC/counter selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        br_d    = br_q;
        case (state_q)
            RUN: begin
                if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
                if (halt_in) begin
                    state_d = HALTED;
                end else if (branch_taken) begin
                    pc_d = lut[br_idx];
                    if (br_q != '1) br_d = br_q + 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cyc_d   = '0;
                    br_d    = '0;
                end
            end
        endcase
    end

    // State, PC and counter registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cyc_q   <= '0;
            br_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            br_q    <= br_d;
        end
    end

    // Branch-target LUT; a same-cycle branch reads the pre-write value
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) lut[i] <= '0;
        end else if (lut_we) begin
            lut[lut_addr] <= lut_data;
        end
    end

    assign pc           = pc_q;
    assign opcode       = instr_in[8:3];
    assign running      = (state_q == RUN);
    assign done         = (state_q == HALTED);
    assign cycle_count  = cyc_q;
    assign branch_count = br_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences,
// and random stimulus against a behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        start;
    logic [8:0]  instr_in;
    logic        branch_taken;
    logic        halt_in;
    logic        lut_we;
    logic [4:0]  lut_addr;
    logic [9:0]  lut_data;

    logic [9:0]  pc, pc4;
    logic [5:0]  opcode, opcode4;
    logic        running, done, running4, done4;
    logic [15:0] cycle_count, branch_count;
    logic [3:0]  cc4, bc4;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .start(start),
        .instr_in(instr_in), .branch_taken(branch_taken),
        .halt_in(halt_in), .lut_we(lut_we),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .pc(pc), .opcode(opcode), .running(running),
        .done(done), .cycle_count(cycle_count),
        .branch_count(branch_count)
    );

    fetch_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .Reset(Reset), .start(start),
        .instr_in(instr_in), .branch_taken(branch_taken),
        .halt_in(halt_in), .lut_we(lut_we),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .pc(pc4), .opcode(opcode4), .running(running4),
        .done(done4), .cycle_count(cc4),
        .branch_count(bc4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       s;
        logic [8:0] instr;
        logic       bt;
        logic       h;
        logic       we;
        logic [4:0] wa;
        logic [9:0] wd;
        int         epc;
        logic       erun;
        logic       edone;
        int         ecyc;
        int         ebr;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [8:0] ins,
                         input logic bt, input logic h, input logic we,
                         input logic [4:0] wa, input logic [9:0] wd);
        start        = s;
        instr_in     = ins;
        branch_taken = bt;
        halt_in      = h;
        lut_we       = we;
        lut_addr     = wa;
        lut_data     = wd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(logic s, logic [8:0] ins, logic bt,
                                logic h, logic we, logic [4:0] wa,
                                logic [9:0] wd, int epc, logic er,
                                logic ed, int ec, int eb);
        vec_t v;
        v.s = s; v.instr = ins; v.bt = bt; v.h = h;
        v.we = we; v.wa = wa; v.wd = wd;
        v.epc = epc; v.erun = er; v.edone = ed;
        v.ecyc = ec; v.ebr = eb;
        return v;
    endfunction

    // behavioural model state
    int mpc, mc, mb, mc4, mb4;
    bit mrun, mhalt;
    int mlut[32];

    task automatic model_reset();
        mpc = 0; mc = 0; mb = 0; mc4 = 0; mb4 = 0;
        mrun = 0; mhalt = 0;
        for (int i = 0; i < 32; i++) mlut[i] = 0;
    endtask

    task automatic model_step();
        if (!mrun) begin
            if (start) begin
                mrun = 1; mhalt = 0; mpc = 0;
                mc = 0; mb = 0; mc4 = 0; mb4 = 0;
            end
        end else begin
            mc  = (mc  < 65535) ? mc + 1  : 65535;
            mc4 = (mc4 < 15)    ? mc4 + 1 : 15;
            if (halt_in) begin
                mrun = 0; mhalt = 1;
            end else if (branch_taken) begin
                mpc = mlut[instr_in % 32];
                mb  = (mb  < 65535) ? mb + 1  : 65535;
                mb4 = (mb4 < 15)    ? mb4 + 1 : 15;
            end else begin
                mpc = (mpc + 1) % 1024;
            end
        end
        if (lut_we) mlut[lut_addr] = lut_data;
    endtask

    localparam logic [8:0] NB = 9'h080;
    localparam logic [8:0] B5 = 9'h085;
    localparam logic [8:0] B6 = 9'h086;

    initial begin
        tbl[0]  = mk(0, NB, 0, 0, 1, 5, 200, 0,   0, 0, 0, 0);
        tbl[1]  = mk(0, NB, 0, 0, 1, 6, 7,   0,   0, 0, 0, 0);
        tbl[2]  = mk(1, NB, 0, 0, 0, 0, 0,   0,   1, 0, 0, 0);
        tbl[3]  = mk(0, NB, 0, 0, 0, 0, 0,   1,   1, 0, 1, 0);
        tbl[4]  = mk(0, NB, 0, 0, 0, 0, 0,   2,   1, 0, 2, 0);
        tbl[5]  = mk(0, NB, 0, 0, 0, 0, 0,   3,   1, 0, 3, 0);
        tbl[6]  = mk(0, NB, 0, 0, 0, 0, 0,   4,   1, 0, 4, 0);
        tbl[7]  = mk(0, NB, 0, 0, 0, 0, 0,   5,   1, 0, 5, 0);
        tbl[8]  = mk(0, NB, 0, 1, 0, 0, 0,   5,   0, 1, 6, 0);
        tbl[9]  = mk(0, NB, 0, 0, 0, 0, 0,   5,   0, 1, 6, 0);
        tbl[10] = mk(1, NB, 0, 0, 0, 0, 0,   0,   1, 0, 0, 0);
        tbl[11] = mk(0, NB, 0, 0, 0, 0, 0,   1,   1, 0, 1, 0);
        tbl[12] = mk(0, NB, 0, 0, 0, 0, 0,   2,   1, 0, 2, 0);
        tbl[13] = mk(0, NB, 0, 0, 0, 0, 0,   3,   1, 0, 3, 0);
        tbl[14] = mk(0, B5, 1, 0, 0, 0, 0,   200, 1, 0, 4, 1);
        tbl[15] = mk(0, B6, 1, 0, 0, 0, 0,   7,   1, 0, 5, 2);
        tbl[16] = mk(0, B5, 1, 1, 0, 0, 0,   7,   0, 1, 6, 2);
        tbl[17] = mk(1, NB, 0, 0, 0, 0, 0,   0,   1, 0, 0, 0);

        drive(0, NB, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_run", running, 0);
        chk("rst_done", done, 0);
        chk("rst_cyc", cycle_count, 0);
        chk("rst_br", branch_count, 0);
        Reset = 1'b0;

        // vector table: run, branch, halt-over-branch, restart
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].s, tbl[i].instr, tbl[i].bt, tbl[i].h,
                  tbl[i].we, tbl[i].wa, tbl[i].wd);
            #1;
            chk("opcode", opcode, tbl[i].instr[8:3]);
            tick();
            chk("tbl_pc", pc, tbl[i].epc);
            chk("tbl_run", running, tbl[i].erun);
            chk("tbl_done", done, tbl[i].edone);
            chk("tbl_cyc", cycle_count, tbl[i].ecyc);
            chk("tbl_br", branch_count, tbl[i].ebr);
        end

        // pc wraps from all-ones to zero
        drive(0, NB, 0, 0, 0, 0, 0);
        repeat (1023) tick();
        chk("pc_top", pc, 1023);
        tick();
        chk("pc_wrap", pc, 0);
        chk("wrap_run", running, 1);

        // same-cycle LUT write and branch: old target first
        drive(0, B5, 1, 0, 1, 5, 300);
        tick();
        chk("lut_old", pc, 200);
        drive(0, B5, 1, 0, 0, 0, 0);
        tick();
        chk("lut_new", pc, 300);
        chk("lut_br", branch_count, 2);

        // async reset between edges
        drive(0, NB, 0, 1, 0, 0, 0);
        tick();
        drive(1, NB, 0, 0, 0, 0, 0);
        tick();
        drive(0, NB, 0, 0, 0, 0, 0);
        repeat (40) tick();
        chk("pre_rst_pc", pc, 40);
        chk("pre_rst_cyc", cycle_count, 40);
        #3;
        Reset = 1'b1;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_run", running, 0);
        chk("arst_cyc", cycle_count, 0);
        #1;
        Reset = 1'b0;
        drive(1, NB, 0, 0, 0, 0, 0);
        tick();
        drive(0, B5, 1, 0, 0, 0, 0);
        tick();
        chk("lut_clr", pc, 0);

        // counter saturation and start ignored in RUN
        for (int i = 0; i < 20; i++) begin
            drive((i == 10), NB, 0, 0, 0, 0, 0);
            tick();
        end
        chk("run_start_pc", pc, 20);
        chk("sat_cyc4", cc4, 15);
        chk("cyc16", cycle_count, 21);
        drive(0, NB, 1, 0, 0, 0, 0);
        repeat (20) tick();
        chk("sat_br4", bc4, 15);
        chk("br16", branch_count, 21);

        // random stimulus against the model
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 19) == 0),
                  9'($urandom_range(0, 511)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 31)),
                  10'($urandom_range(0, 1023)));
            #1;
            chk("r_opc", opcode, 32'(instr_in) >> 3);
            model_step();
            tick();
            chk("r_pc", pc, mpc);
            chk("r_run", running, mrun);
            chk("r_done", done, mhalt);
            chk("r_cyc", cycle_count, mc);
            chk("r_br", branch_count, mb);
            chk("r_cyc4", cc4, mc4);
            chk("r_br4", bc4, mb4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the Control decoder.
- Holds the PC and presents the current instruction's 6-bit opcode to Control.
- Consumes Control's branch/taken/halt results to choose the next PC, using a 32-entry writable branch-target LUT.
- Runs a start/done handshake with the testbench or top level, and keeps cycle and taken-branch counters.

Parameters:
PC_W, 10, PC and instruction-address width in bits
START_ADDR, 0, PC value loaded on reset and on each start
CNT_W, 16, width of cycle_count and branch_count

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that begins a program run
instr_in  input  9  instruction word from instruction memory (combinational read at pc)
branch_taken  input  1  Control branch AND taken for the current instruction
halt_in  input  1  Control halt for the current instruction
lut_we  input  1  branch-target LUT write enable
lut_addr  input  5  LUT write index
lut_data  input  PC_W  LUT write data (absolute target address)
pc  output  PC_W  current instruction address to instruction memory
opcode  output  6  instr_in[8:3] to Control
running  output  1  high only in RUN; downstream gates memory and register writes with it
done  output  1  high in HALTED
cycle_count  output  CNT_W  RUN cycles since last start
branch_count  output  CNT_W  taken branches since last start

Behaviour:
- States:
  - IDLE (reset state)
  - RUN
  - HALTED
- Reset (async, any time, including mid-run):
  - state=IDLE, pc=START_ADDR.
  - cycle_count=0, branch_count=0.
  - All 32 LUT entries=0.
  - running=0, done=0.
- opcode = instr_in[8:3], combinational, in every state. Downstream ignores it when running=0.
- IDLE or HALTED, start=1:
  - Next edge: state=RUN, pc=START_ADDR, both counters cleared.
  - done drops the same edge.
- start while in RUN: ignored.
- RUN, per rising edge, in priority order:
  - halt_in=1: state=HALTED, pc held (points at the halt instruction), branch_taken ignored.
  - else branch_taken=1: pc = LUT[instr_in[4:0]]; branch_count+1.
  - else pc = pc+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
- cycle_count increments on every RUN edge, including the halt edge.
- Both counters saturate at all-ones and never wrap.
- Branch index: instr_in[4:0], i.e. opcode[1:0] concatenated with the 3-bit operand.
- LUT writes:
  - Occur on the clock edge when lut_we=1, in any state.
  - If the write and a taken branch use the same index in the same cycle, the branch uses the pre-write value; the new value is visible from the next cycle.
- Latency:
  - The next PC is visible one edge after the branch/halt decision.
  - No bubbles; one instruction per cycle.
- HALTED: pc, counters and LUT frozen (LUT writes still allowed); done=1 until start or Reset.
- running and done are registered state decodes; they are never both high.

Test Plan:
1. Reset, then start; instr_in a non-branch opcode (6'b010000) for 5 cycles → pc 0,1,2,3,4,5; running=1; cycle_count=5; branch_count=0.
2. LUT[5]=10'd200 written in IDLE; at pc=3, branch_taken=1, instr_in[4:0]=5'd5 → pc=200 next cycle; branch_count=1.
3. halt_in=1 together with branch_taken=1 at pc=7 → state HALTED, pc stays 7, done=1, running=0, branch_count unchanged. Then start → pc=0, counters=0, done=0.
4. PC_W=10, pc reaches 1023 with no branch → next pc=0, running stays 1. Same-cycle lut_we to LUT[5]=300 while branching via index 5 (old value 200) → pc=200; a repeat branch next cycle → pc=300.
5. Assert Reset asynchronously mid-RUN (pc=40, cycle_count=40, between edges) → outputs reset immediately without waiting for CLK; LUT cleared, so a branch after restart lands at 0.
6. Force cycle_count to saturate (CNT_W=4 build, 20 RUN cycles) → holds 15; start during RUN ignored (pc continues incrementing).
